// File: rtl/register_file_rename_pkg.sv
// Shared constants and types for the architectural register file with rename tags.
// The ROB and issue logic import these so tag widths and register ids stay consistent.
package register_file_rename_pkg;

    localparam int DEF_ROB_WIDTH = 4;
    localparam int REG_COUNT     = 32;
    localparam int REG_ID_W      = 5;
    localparam int XLEN          = 32;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]     word_t;

    localparam reg_id_t REG_ZERO = '0;

endpackage

// File: rtl/register_file_rename_if.sv
// Issue/commit/lookup bundle between the register file and the ROB and issue logic.
// The slave modport is the register file side.
interface register_file_rename_if #(
    parameter int ROB_WIDTH = register_file_rename_pkg::DEF_ROB_WIDTH
);
    logic                                  clear_signal;
    logic                                  issue_signal;
    register_file_rename_pkg::reg_id_t     issue_rd_id;
    logic [ROB_WIDTH-1:0]                  issue_rob_tag;
    logic                                  commit_done;
    register_file_rename_pkg::word_t       commit_value;
    register_file_rename_pkg::reg_id_t     commit_id;
    logic [ROB_WIDTH-1:0]                  commit_tag;
    register_file_rename_pkg::reg_id_t     rs1_id;
    register_file_rename_pkg::reg_id_t     rs2_id;
    register_file_rename_pkg::word_t       rs1_value;
    register_file_rename_pkg::word_t       rs2_value;
    logic                                  rs1_pending;
    logic                                  rs2_pending;
    logic [ROB_WIDTH-1:0]                  rs1_tag;
    logic [ROB_WIDTH-1:0]                  rs2_tag;

    modport master (
        output clear_signal, issue_signal, issue_rd_id, issue_rob_tag,
        output commit_done, commit_value, commit_id, commit_tag,
        output rs1_id, rs2_id,
        input  rs1_value, rs2_value, rs1_pending, rs2_pending, rs1_tag, rs2_tag
    );

    modport slave (
        input  clear_signal, issue_signal, issue_rd_id, issue_rob_tag,
        input  commit_done, commit_value, commit_id, commit_tag,
        input  rs1_id, rs2_id,
        output rs1_value, rs2_value, rs1_pending, rs2_pending, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/register_file_rename_rf_read_port.sv
// One combinational operand lookup: selects the register entry and forwards a
// same-cycle commit that retires the tag the register is waiting on.
module rf_read_port
    import register_file_rename_pkg::*;
#(
    parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
    input  reg_id_t                             rs_id,
    input  logic [REG_COUNT-1:0][XLEN-1:0]      value_rf,
    input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag_rf,
    input  logic [REG_COUNT-1:0]                pending_rf,
    input  logic                                commit_done,
    input  reg_id_t                             commit_id,
    input  word_t                               commit_value,
    input  logic [ROB_WIDTH-1:0]                commit_tag,
    output word_t                               rs_value,
    output logic                                rs_pending,
    output logic [ROB_WIDTH-1:0]                rs_tag
);
    logic bypass;

    // x0 never goes pending, so the pending term alone keeps it out of the bypass;
    // the explicit id check documents that intent.
    always_comb begin
        bypass     = commit_done && (commit_id == rs_id) && (rs_id != REG_ZERO) &&
                     pending_rf[rs_id] && (tag_rf[rs_id] == commit_tag);
        rs_value   = bypass ? commit_value : value_rf[rs_id];
        rs_pending = pending_rf[rs_id] && !bypass;
        rs_tag     = tag_rf[rs_id];
    end

endmodule

// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags: records issue-time
// ROB tags, retires them on in-order commit, and serves two bypassed lookups.
module register_file_rename
    import register_file_rename_pkg::*;
#(
    parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    register_file_rename_if.slave rf_bus
);
    logic [REG_COUNT-1:0][XLEN-1:0]      value_q;
    logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag_q;
    logic [REG_COUNT-1:0]                pending_q;

    logic [REG_COUNT-1:0] commit_sel;
    logic [REG_COUNT-1:0] issue_sel;
    logic [REG_COUNT-1:0] retire_sel;

    // Entry 0 is left out of every select so x0 stays zero and never pending.
    always_comb begin
        commit_sel = '0;
        issue_sel  = '0;
        retire_sel = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            commit_sel[i] = rf_bus.commit_done && (rf_bus.commit_id == reg_id_t'(i));
            issue_sel[i]  = rf_bus.issue_signal && !rf_bus.clear_signal &&
                            (rf_bus.issue_rd_id == reg_id_t'(i));
            retire_sel[i] = commit_sel[i] && pending_q[i] && (tag_q[i] == rf_bus.commit_tag);
        end
    end

    // Issue overrides a same-cycle retire; clear drops every pending bit but commit
    // still lands its value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value_q   <= '0;
            tag_q     <= '0;
            pending_q <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (commit_sel[i]) value_q[i] <= rf_bus.commit_value;
                if (issue_sel[i])  tag_q[i]   <= rf_bus.issue_rob_tag;
            end
            pending_q <= (pending_q & ~retire_sel & {REG_COUNT{!rf_bus.clear_signal}}) | issue_sel;
        end
    end

    rf_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1_port (
        .rs_id        (rf_bus.rs1_id),
        .value_rf     (value_q),
        .tag_rf       (tag_q),
        .pending_rf   (pending_q),
        .commit_done  (rf_bus.commit_done),
        .commit_id    (rf_bus.commit_id),
        .commit_value (rf_bus.commit_value),
        .commit_tag   (rf_bus.commit_tag),
        .rs_value     (rf_bus.rs1_value),
        .rs_pending   (rf_bus.rs1_pending),
        .rs_tag       (rf_bus.rs1_tag)
    );

    rf_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2_port (
        .rs_id        (rf_bus.rs2_id),
        .value_rf     (value_q),
        .tag_rf       (tag_q),
        .pending_rf   (pending_q),
        .commit_done  (rf_bus.commit_done),
        .commit_id    (rf_bus.commit_id),
        .commit_value (rf_bus.commit_value),
        .commit_tag   (rf_bus.commit_tag),
        .rs_value     (rf_bus.rs2_value),
        .rs_pending   (rf_bus.rs2_pending),
        .rs_tag       (rf_bus.rs2_tag)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against an array-based model of the register file.
module tb_register_file_rename;
    localparam int RW = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    register_file_rename_if #(.ROB_WIDTH(RW)) bus ();

    register_file_rename #(.ROB_WIDTH(RW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rf_bus (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic [31:0]   m_val  [32];
    logic [RW-1:0] m_tag  [32];
    logic          m_pend [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: commit lands value and may retire the matching tag, clear wipes all
    // pending bits, otherwise an issue (re)names rd.
    int c_id;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_tag[i] = '0; m_pend[i] = 1'b0;
            end
        end else if (rdy_in) begin
            if (bus.commit_done && bus.commit_id != 5'd0) begin
                c_id = int'(bus.commit_id);
                m_val[c_id] = bus.commit_value;
                if (m_pend[c_id] && m_tag[c_id] == bus.commit_tag) m_pend[c_id] = 1'b0;
            end
            if (bus.clear_signal) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else if (bus.issue_signal && bus.issue_rd_id != 5'd0) begin
                m_tag[bus.issue_rd_id]  = bus.issue_rob_tag;
                m_pend[bus.issue_rd_id] = 1'b1;
            end
        end
    end

    function automatic void lookup(input logic [4:0] id, output logic [31:0] v,
                                   output logic p, output logic [RW-1:0] t, output logic byp);
        byp = bus.commit_done && bus.commit_id == id && id != 5'd0 &&
              m_pend[id] && m_tag[id] == bus.commit_tag;
        v   = byp ? bus.commit_value : m_val[id];
        p   = m_pend[id] && !byp;
        t   = m_tag[id];
    endfunction

    logic [31:0]   e_v;
    logic          e_p, e_b;
    logic [RW-1:0] e_t;
    always @(negedge clk_in) begin
        if (chk_en) begin
            lookup(bus.rs1_id, e_v, e_p, e_t, e_b);
            check("rs1_value", bus.rs1_value, e_v);
            check("rs1_pending", 32'(bus.rs1_pending), 32'(e_p));
            if (!e_b) check("rs1_tag", 32'(bus.rs1_tag), 32'(e_t));
            lookup(bus.rs2_id, e_v, e_p, e_t, e_b);
            check("rs2_value", bus.rs2_value, e_v);
            check("rs2_pending", 32'(bus.rs2_pending), 32'(e_p));
            if (!e_b) check("rs2_tag", 32'(bus.rs2_tag), 32'(e_t));
        end
    end

    task automatic idle();
        rdy_in = 1'b1;
        bus.clear_signal = 1'b0;
        bus.issue_signal = 1'b0; bus.issue_rd_id = '0; bus.issue_rob_tag = '0;
        bus.commit_done  = 1'b0; bus.commit_id = '0; bus.commit_value = '0; bus.commit_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] tag);
        bus.issue_signal = 1'b1; bus.issue_rd_id = rd; bus.issue_rob_tag = tag;
    endtask

    task automatic commit(input logic [4:0] id, input logic [RW-1:0] tag, input logic [31:0] v);
        bus.commit_done = 1'b1; bus.commit_id = id; bus.commit_tag = tag; bus.commit_value = v;
    endtask

    task automatic lit1(input string nm, input logic [31:0] v, input logic p, input logic [RW-1:0] t);
        check({nm, "_value"}, bus.rs1_value, v);
        check({nm, "_pending"}, 32'(bus.rs1_pending), 32'(p));
        check({nm, "_tag"}, 32'(bus.rs1_tag), 32'(t));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_pend[i] = 1'b0;
        end
        idle();
        bus.rs1_id = 5'd5; bus.rs2_id = 5'd0;
        #12;
        lit1("reset_rs1", 32'h0, 1'b0, 4'd0);
        rst_in = 1'b1;
        chk_en = 1'b1;
        tick();

        // Rename, lookup, then retire with same-cycle bypass.
        issue(5'd3, 4'd7); tick(); idle();
        bus.rs1_id = 5'd3; #1;
        lit1("issue_x3", 32'h0, 1'b1, 4'd7);
        commit(5'd3, 4'd7, 32'h1234); #1;
        check("bypass_x3_value", bus.rs1_value, 32'h1234);
        check("bypass_x3_pending", 32'(bus.rs1_pending), 32'd0);
        tick(); idle(); #1;
        lit1("commit_x3", 32'h1234, 1'b0, 4'd7);

        // Older commit against a younger rename: no retire, no bypass.
        issue(5'd4, 4'd2); tick(); idle();
        issue(5'd4, 4'd5); tick(); idle();
        bus.rs1_id = 5'd4;
        commit(5'd4, 4'd2, 32'hAA); #1;
        check("stale_commit_value", bus.rs1_value, 32'h0);
        check("stale_commit_pending", 32'(bus.rs1_pending), 32'd1);
        tick(); idle(); #1;
        lit1("stale_x4", 32'hAA, 1'b1, 4'd5);

        // Same-cycle issue and commit to one register.
        issue(5'd6, 4'd1); tick(); idle();
        issue(5'd6, 4'd9); commit(5'd6, 4'd1, 32'h55); tick(); idle();
        bus.rs1_id = 5'd6; #1;
        lit1("issue_commit_x6", 32'h55, 1'b1, 4'd9);

        // Flush with a landing commit and an ignored issue.
        issue(5'd1, 4'd3); tick(); idle();
        issue(5'd2, 4'd4); tick(); idle();
        commit(5'd1, 4'd3, 32'h80); issue(5'd7, 4'd6); bus.clear_signal = 1'b1;
        tick(); idle();
        bus.rs1_id = 5'd1; bus.rs2_id = 5'd2; #1;
        lit1("clear_x1", 32'h80, 1'b0, 4'd3);
        check("clear_x2_pending", 32'(bus.rs2_pending), 32'd0);
        bus.rs1_id = 5'd7; #1;
        check("clear_x7_pending", 32'(bus.rs1_pending), 32'd0);

        // x0 is never written nor renamed.
        issue(5'd0, 4'd8); commit(5'd0, 4'd8, 32'hFFFF); tick(); idle();
        bus.rs1_id = 5'd0; #1;
        lit1("x0", 32'h0, 1'b0, 4'd0);

        // Paused cycle changes nothing.
        rdy_in = 1'b0; issue(5'd8, 4'd3); commit(5'd3, 4'd7, 32'hDEAD); tick(); idle();
        bus.rs1_id = 5'd3; bus.rs2_id = 5'd8; #1;
        lit1("paused_x3", 32'h1234, 1'b0, 4'd7);
        check("paused_x8_pending", 32'(bus.rs2_pending), 32'd0);

        // Random traffic on a narrow register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rdy_in             = ($urandom_range(0, 7) != 0);
            bus.clear_signal   = ($urandom_range(0, 15) == 0);
            bus.issue_signal   = 1'($urandom_range(0, 1));
            bus.issue_rd_id    = 5'($urandom_range(0, 7));
            bus.issue_rob_tag  = RW'($urandom_range(0, 15));
            bus.commit_done    = 1'($urandom_range(0, 1));
            bus.commit_id      = 5'($urandom_range(0, 7));
            bus.commit_tag     = ($urandom_range(0, 2) != 0) ? m_tag[bus.commit_id]
                                                              : RW'($urandom_range(0, 15));
            bus.commit_value   = $urandom;
            bus.rs1_id         = ($urandom_range(0, 1) != 0) ? bus.commit_id : 5'($urandom_range(0, 7));
            bus.rs2_id         = 5'($urandom_range(0, 7));
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        tick(); idle();
        for (int i = 1; i < 8; i++) begin
            commit(5'(i), 4'd0, 32'h100 + i); tick();
        end
        idle(); issue(5'd5, 4'd11); tick(); idle();
        bus.rs1_id = 5'd3; bus.rs2_id = 5'd5; #1;
        check("pre_reset_x3", bus.rs1_value, 32'h103);
        #1 rst_in = 1'b0;
        #1;
        lit1("async_reset_x3", 32'h0, 1'b0, 4'd0);
        check("async_reset_x5_value", bus.rs2_value, 32'h0);
        check("async_reset_x5_pending", 32'(bus.rs2_pending), 32'd0);
        @(negedge clk_in); #1 rst_in = 1'b1;
        tick(); tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
